// File: rtl/msg_source_framer_if.sv
// Beat-in / framed-word-out link between portal logic and the host-bound framer.
// master is the environment side; slave is the framer side.
interface msg_source_framer_if #(
  parameter int width = 32
);
  logic             EN_beat;
  logic             RDY_beat;
  logic [width-1:0] beat;
  logic             last;
  logic [15:0]      method_id;
  logic             EN_msg;
  logic             RDY_msg;
  logic [width-1:0] msg;
  logic             msg_last;
  logic             overflow;

  modport master (
    output EN_beat, beat, last, method_id, RDY_msg,
    input  RDY_beat, EN_msg, msg, msg_last, overflow
  );

  modport slave (
    input  EN_beat, beat, last, method_id, RDY_msg,
    output RDY_beat, EN_msg, msg, msg_last, overflow
  );
endinterface

// File: rtl/msg_source_framer.sv
// Store-and-forward framer: buffers a whole message, then emits a
// {method_id, length} header followed by the payload beats.
module msg_source_framer #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input logic                 CLK,
  input logic                 RST,
  msg_source_framer_if.slave  bus
);

  localparam int CW = $clog2(depth + 1);
  localparam int AW = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(depth - 1);

  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    rd_q, rd_d;
  logic [15:0]      mid_q, mid_d;
  logic             ovf_q, ovf_d;
  logic [width-1:0] buf_q [depth];

  logic             rdyBeat;
  logic             enMsg;
  logic             beatXfer;
  logic             msgXfer;
  logic             lastWord;
  logic [15:0]      len;
  logic [width-1:0] msgWord;

  assign rdyBeat  = (state_q == FILL);
  assign enMsg    = (state_q == HDR) || (state_q == DATA);
  assign beatXfer = bus.EN_beat && rdyBeat;
  assign msgXfer  = enMsg && bus.RDY_msg;
  assign lastWord = (state_q == DATA) && (rd_q == (count_q - CW'(1)));
  // Length counts the header word as well as the payload beats.
  assign len      = 16'(count_q) + 16'd1;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rd_d    = rd_q;
    mid_d   = mid_q;
    ovf_d   = ovf_q;
    case (state_q)
      FILL: begin
        if (beatXfer) begin
          count_d = count_q + CW'(1);
          if (count_q == '0) mid_d = bus.method_id;
          if (bus.last) begin
            state_d = HDR;
          end else if (count_q == LAST_IDX) begin
            // Buffer full without a last: close the message here and flag it.
            state_d = HDR;
            ovf_d   = 1'b1;
          end
        end
      end
      HDR: begin
        if (msgXfer) begin
          rd_d    = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (msgXfer) begin
          rd_d = rd_q + CW'(1);
          if (lastWord) begin
            count_d = '0;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    msgWord = '0;
    if (state_q == HDR) begin
      msgWord[31:0] = {mid_q, len};
    end else if (state_q == DATA) begin
      msgWord = buf_q[rd_q[AW-1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FILL;
      count_q <= '0;
      rd_q    <= '0;
      mid_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      mid_q   <= mid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Payload storage needs no reset; stale entries are never read back.
  always_ff @(posedge CLK) begin
    if (beatXfer && !RST) begin
      buf_q[count_q[AW-1:0]] <= bus.beat;
    end
  end

  assign bus.RDY_beat = rdyBeat;
  assign bus.EN_msg   = enMsg;
  assign bus.msg      = msgWord;
  assign bus.msg_last = lastWord;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_msg_source_framer.sv
// Directed bench for msg_source_framer: per-cycle vector table followed by
// hand-written overflow, reset-in-DATA and recovery sequences.
module tb_msg_source_framer;

  logic CLK;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  msg_source_framer_if #(.width(32)) bus ();

  msg_source_framer #(.width(32), .depth(16)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] beat;
    logic        last;
    logic [15:0] mid;
    logic        rdy;
    logic        chk;
    logic        eRdyBeat;
    logic        eEn;
    logic [31:0] eMsg;
    logic        eLast;
  } vec_t;

  vec_t        vecs[30];
  logic        capture = 1'b0;
  logic [31:0] seen[$];
  logic [31:0] expSeen[11];

  // Record every accepted output word while the table phase runs.
  always @(posedge CLK) begin
    if (capture && !RST && bus.EN_msg && bus.RDY_msg) seen.push_back(bus.msg);
  end

  function automatic vec_t mk(logic rst, logic en, logic [31:0] b, logic l,
                              logic [15:0] m, logic r, logic c, logic eRb,
                              logic eEn, logic [31:0] eMsg, logic eL);
    vec_t v;
    v.rst = rst; v.en = en; v.beat = b; v.last = l; v.mid = m; v.rdy = r;
    v.chk = c; v.eRdyBeat = eRb; v.eEn = eEn; v.eMsg = eMsg; v.eLast = eL;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    RST           = v.rst;
    bus.EN_beat   = v.en;
    bus.beat      = v.beat;
    bus.last      = v.last;
    bus.method_id = v.mid;
    bus.RDY_msg   = v.rdy;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic beatIn(input logic [31:0] b, input logic l, input logic [15:0] m);
    bus.EN_beat   = 1'b1;
    bus.beat      = b;
    bus.last      = l;
    bus.method_id = m;
    step();
    bus.EN_beat   = 1'b0;
  endtask

  task automatic checkWord(input string name, input logic [31:0] w, input logic l);
    checkOutput({name, " en"},   32'(bus.EN_msg), 32'd1);
    checkOutput({name, " msg"},  bus.msg, w);
    checkOutput({name, " last"}, 32'(bus.msg_last), 32'(l));
  endtask

  initial begin
    // rst en beat last mid rdy | chk rdyBeat enMsg msg msgLast
    vecs[0]  = mk(1, 0, 32'h0,    0, 16'h0,    0, 0, 0, 0, 32'h0,        0);
    vecs[1]  = mk(0, 1, 32'hA1,   0, 16'h0005, 1, 1, 1, 0, 32'h0,        0);
    vecs[2]  = mk(0, 1, 32'hA2,   0, 16'h0005, 1, 1, 1, 0, 32'h0,        0);
    vecs[3]  = mk(0, 1, 32'hA3,   1, 16'h0005, 1, 1, 1, 0, 32'h0,        0);
    vecs[4]  = mk(0, 1, 32'hBAD,  0, 16'h9999, 1, 1, 0, 1, 32'h00050004, 0);
    vecs[5]  = mk(0, 1, 32'hBAD,  0, 16'h9999, 1, 1, 0, 1, 32'hA1,       0);
    vecs[6]  = mk(0, 1, 32'hBAD,  0, 16'h9999, 1, 1, 0, 1, 32'hA2,       0);
    vecs[7]  = mk(0, 1, 32'hBAD,  0, 16'h9999, 1, 1, 0, 1, 32'hA3,       1);
    vecs[8]  = mk(0, 1, 32'hDEAD, 1, 16'h0102, 1, 1, 1, 0, 32'h0,        0);
    vecs[9]  = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'h01020002, 0);
    vecs[10] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'hDEAD,     1);
    vecs[11] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 1, 0, 32'h0,        0);
    vecs[12] = mk(0, 1, 32'h11,   0, 16'h0007, 0, 1, 1, 0, 32'h0,        0);
    vecs[13] = mk(0, 1, 32'h22,   0, 16'h0007, 0, 1, 1, 0, 32'h0,        0);
    vecs[14] = mk(0, 1, 32'h33,   0, 16'h0007, 0, 1, 1, 0, 32'h0,        0);
    vecs[15] = mk(0, 1, 32'h44,   1, 16'h0007, 0, 1, 1, 0, 32'h0,        0);
    vecs[16] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'h00070005, 0);
    vecs[17] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h11,       0);
    vecs[18] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h11,       0);
    vecs[19] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'h11,       0);
    vecs[20] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h22,       0);
    vecs[21] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h22,       0);
    vecs[22] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'h22,       0);
    vecs[23] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h33,       0);
    vecs[24] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h33,       0);
    vecs[25] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'h33,       0);
    vecs[26] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h44,       1);
    vecs[27] = mk(0, 0, 32'h0,    0, 16'h0,    0, 1, 0, 1, 32'h44,       1);
    vecs[28] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 0, 1, 32'h44,       1);
    vecs[29] = mk(0, 0, 32'h0,    0, 16'h0,    1, 1, 1, 0, 32'h0,        0);

    expSeen = '{32'h00050004, 32'hA1, 32'hA2, 32'hA3, 32'h01020002, 32'hDEAD,
                32'h00070005, 32'h11, 32'h22, 32'h33, 32'h44};

    RST = 1'b1; bus.EN_beat = 1'b0; bus.beat = '0; bus.last = 1'b0;
    bus.method_id = '0; bus.RDY_msg = 1'b0;

    capture = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      applyStimulus(vecs[i]);
      if (vecs[i].chk) begin
        checkOutput($sformatf("v%0d rdyBeat", i), 32'(bus.RDY_beat), 32'(vecs[i].eRdyBeat));
        checkOutput($sformatf("v%0d enMsg", i),   32'(bus.EN_msg),   32'(vecs[i].eEn));
        checkOutput($sformatf("v%0d msg", i),     bus.msg,           vecs[i].eMsg);
        checkOutput($sformatf("v%0d msgLast", i), 32'(bus.msg_last), 32'(vecs[i].eLast));
        checkOutput($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'd0);
      end
    end
    @(negedge CLK);
    capture = 1'b0;
    bus.EN_beat = 1'b0;
    bus.RDY_msg = 1'b0;

    checkOutput("xfer count", 32'(seen.size()), 32'd11);
    for (int i = 0; i < 11; i++) begin
      if (i < seen.size()) checkOutput($sformatf("xfer %0d", i), seen[i], expSeen[i]);
    end

    // Forced termination: 16 beats without last close the message at depth.
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("ovf rdyBeat %0d", i), 32'(bus.RDY_beat), 32'd1);
      beatIn(32'h100 + 32'(i), 1'b0, 16'h0AAA);
    end
    checkOutput("ovf flag",     32'(bus.overflow), 32'd1);
    checkOutput("ovf rdyBeat",  32'(bus.RDY_beat), 32'd0);
    checkWord("ovf hdr", 32'h0AAA0011, 1'b0);
    bus.EN_beat = 1'b1; bus.beat = 32'hBAD; bus.last = 1'b0; bus.method_id = 16'hEEEE;
    bus.RDY_msg = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      checkWord($sformatf("ovf data %0d", i), 32'h100 + 32'(i), i == 15);
      step();
    end
    bus.EN_beat = 1'b0;
    checkOutput("ovf idle rdyBeat", 32'(bus.RDY_beat), 32'd1);
    checkOutput("ovf idle enMsg",   32'(bus.EN_msg),   32'd0);
    for (int i = 0; i < 4; i++) beatIn(32'h110 + 32'(i), 1'b0, 16'h0BBB);
    beatIn(32'h114, 1'b1, 16'h0CCC);
    checkWord("ovf2 hdr", 32'h0BBB0006, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      checkWord($sformatf("ovf2 data %0d", i), 32'h110 + 32'(i), i == 4);
      step();
    end
    checkOutput("ovf sticky", 32'(bus.overflow), 32'd1);

    // Reset while draining: partial message discarded, overflow cleared.
    for (int i = 0; i < 3; i++) beatIn(32'h50 + 32'(i), 1'b0, 16'h000C);
    beatIn(32'h53, 1'b1, 16'h000C);
    checkWord("rst hdr", 32'h000C0005, 1'b0);
    step();
    checkWord("rst data0", 32'h50, 1'b0);
    step();
    checkWord("rst data1", 32'h51, 1'b0);
    RST = 1'b1;
    bus.RDY_msg = 1'b0;
    step();
    RST = 1'b0;
    checkOutput("rst enMsg",    32'(bus.EN_msg),   32'd0);
    checkOutput("rst rdyBeat",  32'(bus.RDY_beat), 32'd1);
    checkOutput("rst overflow", 32'(bus.overflow), 32'd0);
    checkOutput("rst msg",      bus.msg,           32'd0);
    checkOutput("rst msgLast",  32'(bus.msg_last), 32'd0);
    beatIn(32'h77, 1'b1, 16'h000D);
    bus.RDY_msg = 1'b1;
    checkWord("post hdr", 32'h000D0002, 1'b0);
    step();
    checkWord("post data", 32'h77, 1'b1);
    step();
    checkOutput("post enMsg",   32'(bus.EN_msg),   32'd0);
    checkOutput("post rdyBeat", 32'(bus.RDY_beat), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
